c7bifu_brt: RTL
===============

Name: c7bifu_brt

Overview:
Branch target/redirect unit in the IFU, downstream of the immediate decoder.
- Consumes decoded branch offsets (already sign-extended and shifted left by 2) together with the branch PC.
- Resolves the target and issues a single-outstanding redirect request to fetch over a valid/ready handshake.
- For conditional branches and register-indirect jumps, waits for the operand or condition to arrive from the execute side.

Parameters:
PC_W, 32, width of PC, offset and target datapaths
RESET_TGT, 32'h1c000000, value held on redir_pc out of reset

Ports:
clk  input  1  core clock
resetn  input  1  asynchronous active-low reset
dec_valid  input  1  decoded branch presented
dec_ready  output  1  unit can accept a branch
dec_pc  input  PC_W  PC of branch instruction
dec_br_offs  input  PC_W  byte offset from decoder (sign-extended, <<2)
dec_kind  input  2  00 reserved, 01 PC-rel unconditional, 10 PC-rel conditional, 11 register-indirect (jirl)
cond_valid  input  1  condition result available (kind 10)
cond_taken  input  1  condition result
rj_valid  input  1  base register value available (kind 11)
rj_data  input  PC_W  base register value
flush  input  1  pipeline flush; cancels any in-flight branch
redir_valid  output  1  redirect request to fetch
redir_ready  input  1  fetch accepts redirect
redir_pc  output  PC_W  redirect target
bt_done  output  1  one-cycle pulse: branch retired by this unit
bt_taken  output  1  qualifies bt_done
exc_ade  output  1  one-cycle pulse: misaligned jirl target

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-low, resetn.
- Reset values: state=IDLE, redir_pc=RESET_TGT, kind/target regs=0, bt_done=0, bt_taken=0, exc_ade=0.
- States: IDLE, WAIT_OP, REDIR.
- dec_ready = (state==IDLE). Accept = dec_valid & dec_ready & !flush.
- Target adder on accept: tgt = dec_pc + dec_br_offs, mod 2^PC_W, wrap-around ignored.
- IDLE, on accept, by kind:
  - 01: register tgt, go to REDIR. redir_valid rises the cycle after accept (latency 1).
  - 10: register tgt, go to WAIT_OP.
  - 11: register offset, go to WAIT_OP.
  - 00: dropped; stay IDLE; no pulse.
- WAIT_OP, kind 10, on cond_valid:
  - taken: go to REDIR.
  - not taken: go to IDLE, pulse bt_done=1, bt_taken=0 the next cycle.
- WAIT_OP, kind 11, on rj_valid:
  - compute t = rj_data + offset.
  - t[1:0] != 0: go to IDLE, pulse exc_ade the next cycle; no redirect, no bt_done.
  - otherwise: redir_pc <= t, go to REDIR.
- Strobes for the wrong kind are ignored (cond_valid during a kind-11 branch, rj_valid during a kind-10 branch).
- REDIR:
  - redir_valid = (state==REDIR) & !flush.
  - redir_pc stays stable until the handshake completes.
  - On redir_valid & redir_ready: go to IDLE, pulse bt_done=1, bt_taken=1 the next cycle.
  - Back-to-back: a new branch can be accepted the cycle after returning to IDLE (min 2 cycles per redirect).
- flush, highest priority:
  - From any state, state <= IDLE next cycle.
  - Same-cycle cond_valid/rj_valid/redir_ready/dec_valid have no effect.
  - No bt_done or exc_ade is generated for the cancelled branch.
  - redir_pc keeps its last value.
- Reset mid-operation: immediate return to IDLE; any pending redirect is lost.
- bt_done, bt_taken and exc_ade are registered and never high in the same cycle.

Decomposition:
- Shared dec_defs.v additions:
  - BRK_NONE/BRK_PCREL/BRK_COND/BRK_IND kind encodings.
  - BRT_IDLE/BRT_WAIT/BRT_REDIR state encodings.
- One natural sub-module: c7bifu_brt_add, a PC_W-bit target adder with an operand mux (dec_pc vs rj_data). It is instanced once and shared between the accept path and the WAIT_OP path.

Test Plan:
1. Uncond, redir_ready tied high: dec_pc=0x1c000100, offs=0x40, kind 01 → cycle+1 redir_valid=1, redir_pc=0x1c000140; cycle+2 bt_done=1, bt_taken=1, dec_ready=1.
2. Conditional not taken: pc=0x1000, offs=0xFFFFFFF8, kind 10; cond_valid=1, cond_taken=0 at cycle+3 → no redir_valid; bt_done=1, bt_taken=0 at cycle+4. Repeat with taken → redir_pc=0x0FF8.
3. jirl: offs=0x10, rj_data=0x2000 after 2 wait cycles → redir_pc=0x2010. Repeat with rj_data=0x2002 → exc_ade pulse, no redirect, no bt_done.
4. Backpressure: redir_ready low 5 cycles → redir_valid and redir_pc=target held constant; dec_ready=0 throughout; exactly one bt_done after the ready cycle.
5. Flush during REDIR, with redir_ready=1 in the flush cycle → redir_valid=0 that cycle, IDLE next cycle, no bt_done. Flush in WAIT_OP coinciding with cond_valid → no pulse.
6. resetn asserted asynchronously mid-WAIT_OP → outputs at reset values immediately: redir_pc=0x1c000000, dec_ready=1 after release.

Source files
------------

// File: rtl/c7bifu_brt_pkg.sv
// rtl/c7bifu_brt_pkg.sv - shared encodings for the IFU branch target/redirect unit
package c7bifu_brt_pkg;

    // Branch kind as delivered by the immediate decoder
    typedef enum logic [1:0] {
        BRK_NONE  = 2'b00,
        BRK_PCREL = 2'b01,
        BRK_COND  = 2'b10,
        BRK_IND   = 2'b11
    } brk_kind_e;

    // Redirect unit state
    typedef enum logic [1:0] {
        BRT_IDLE  = 2'b00,
        BRT_WAIT  = 2'b01,
        BRT_REDIR = 2'b10
    } brt_state_e;

    // Instruction fetch targets must be word aligned
    function automatic logic brt_misaligned(input logic [1:0] lsb);
        return (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/c7bifu_brt_add.sv
// rtl/c7bifu_brt_add.sv - shared target adder with base-operand mux
module c7bifu_brt_add #(
    parameter int PC_W = 32
) (
    input  logic            i_sel_rj,
    input  logic [PC_W-1:0] i_pc,
    input  logic [PC_W-1:0] i_rj,
    input  logic [PC_W-1:0] i_offs,
    output logic [PC_W-1:0] o_sum
);

    logic [PC_W-1:0] w_base;

    // Base is the branch PC on accept, the jirl base register while waiting
    assign w_base = i_sel_rj ? i_rj : i_pc;
    assign o_sum  = w_base + i_offs;

endmodule

// File: rtl/c7bifu_brt.sv
// rtl/c7bifu_brt.sv - branch target resolve and single-outstanding fetch redirect
module c7bifu_brt
    import c7bifu_brt_pkg::*;
#(
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_TGT = 32'h1c000000
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            dec_valid,
    output logic            dec_ready,
    input  logic [PC_W-1:0] dec_pc,
    input  logic [PC_W-1:0] dec_br_offs,
    input  logic [1:0]      dec_kind,
    input  logic            cond_valid,
    input  logic            cond_taken,
    input  logic            rj_valid,
    input  logic [PC_W-1:0] rj_data,
    input  logic            flush,
    output logic            redir_valid,
    input  logic            redir_ready,
    output logic [PC_W-1:0] redir_pc,
    output logic            bt_done,
    output logic            bt_taken,
    output logic            exc_ade
);

    brt_state_e      r_state;
    brk_kind_e       r_kind;
    logic [PC_W-1:0] r_tgt;        // PC-relative target, or jirl offset while waiting for rj
    logic [PC_W-1:0] r_redir_pc;
    logic            r_bt_done;
    logic            r_bt_taken;
    logic            r_exc_ade;

    logic            w_sel_rj;
    logic [PC_W-1:0] w_offs;
    logic [PC_W-1:0] w_sum;

    // While waiting the adder sums rj with the held offset; otherwise decoder PC + offset
    assign w_sel_rj = (r_state == BRT_WAIT);
    assign w_offs   = w_sel_rj ? r_tgt : dec_br_offs;

    c7bifu_brt_add #(
        .PC_W (PC_W)
    ) u_add (
        .i_sel_rj (w_sel_rj),
        .i_pc     (dec_pc),
        .i_rj     (rj_data),
        .i_offs   (w_offs),
        .o_sum    (w_sum)
    );

    assign dec_ready   = (r_state == BRT_IDLE);
    assign redir_valid = (r_state == BRT_REDIR) & ~flush;
    assign redir_pc    = r_redir_pc;
    assign bt_done     = r_bt_done;
    assign bt_taken    = r_bt_taken;
    assign exc_ade     = r_exc_ade;

    // Redirect FSM; flush overrides every other event and suppresses all pulses
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= BRT_IDLE;
            r_kind     <= BRK_NONE;
            r_tgt      <= '0;
            r_redir_pc <= RESET_TGT;
            r_bt_done  <= 1'b0;
            r_bt_taken <= 1'b0;
            r_exc_ade  <= 1'b0;
        end else begin
            r_bt_done  <= 1'b0;
            r_bt_taken <= 1'b0;
            r_exc_ade  <= 1'b0;
            if (flush) begin
                r_state <= BRT_IDLE;
            end else begin
                case (r_state)
                    BRT_IDLE: begin
                        if (dec_valid) begin
                            r_kind <= brk_kind_e'(dec_kind);
                            case (brk_kind_e'(dec_kind))
                                BRK_PCREL: begin
                                    r_tgt      <= w_sum;
                                    r_redir_pc <= w_sum;
                                    r_state    <= BRT_REDIR;
                                end
                                BRK_COND: begin
                                    r_tgt   <= w_sum;
                                    r_state <= BRT_WAIT;
                                end
                                BRK_IND: begin
                                    r_tgt   <= dec_br_offs;
                                    r_state <= BRT_WAIT;
                                end
                                default: begin
                                    r_state <= BRT_IDLE;
                                end
                            endcase
                        end
                    end
                    BRT_WAIT: begin
                        if ((r_kind == BRK_COND) && cond_valid) begin
                            if (cond_taken) begin
                                r_redir_pc <= r_tgt;
                                r_state    <= BRT_REDIR;
                            end else begin
                                r_bt_done <= 1'b1;
                                r_state   <= BRT_IDLE;
                            end
                        end else if ((r_kind == BRK_IND) && rj_valid) begin
                            if (brt_misaligned(w_sum[1:0])) begin
                                r_exc_ade <= 1'b1;
                                r_state   <= BRT_IDLE;
                            end else begin
                                r_redir_pc <= w_sum;
                                r_state    <= BRT_REDIR;
                            end
                        end
                    end
                    BRT_REDIR: begin
                        if (redir_ready) begin
                            r_bt_done  <= 1'b1;
                            r_bt_taken <= 1'b1;
                            r_state    <= BRT_IDLE;
                        end
                    end
                    default: begin
                        r_state <= BRT_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
